// File: rtl/nios_wallet_dbg_pkg.sv
// rtl/nios_wallet_dbg_pkg.sv - debug command IR encodings, defaults and queue entry type
package nios_wallet_dbg_pkg;

  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  localparam int DBG_SR_W    = 38;
  localparam int DBG_IR_W    = 2;
  localparam int DBG_ACT_BIT = 34;

  typedef struct packed {
    logic [DBG_IR_W-1:0] ir;
    logic [DBG_SR_W-1:0] sr;
  } dbg_cmd_t;

endpackage

// File: rtl/nios_wallet_dbg_cmd_fifo.sv
// rtl/nios_wallet_dbg_cmd_fifo.sv - command queue with wrapping pointers and occupancy count
module nios_wallet_dbg_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_wr_en;
  logic          w_rd_en;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_rd_en = i_pop & ~o_empty;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign w_wr_en = i_push & (~o_full | w_rd_en);
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + {{AW{1'b0}}, w_wr_en} - {{AW{1'b0}}, w_rd_en};
    end
  end

endmodule

// File: rtl/nios_wallet_cpu_dbg_cmd_rx.sv
// rtl/nios_wallet_cpu_dbg_cmd_rx.sv - sysclk debug command receiver; DBG_CMD_PARITY_EN enables the scan parity check
module nios_wallet_cpu_dbg_cmd_rx
  import nios_wallet_dbg_pkg::*;
#(
  parameter int SR_W        = DBG_SR_W,
  parameter int IR_W        = DBG_IR_W,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4,
  parameter int ACT_BIT     = DBG_ACT_BIT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 vs_udr,
  input  logic                 vs_uir,
  input  logic [IR_W-1:0]      ir_in,
  input  logic [SR_W-1:0]      sr,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [SR_W-1:0]      jdo,
  output logic [IR_W-1:0]      cmd_ir,
  output logic [IR_W-1:0]      ir_latched,
  output logic [(1<<IR_W)-1:0] take_action,
  output logic [(1<<IR_W)-1:0] take_no_action,
  output logic                 ovf,
  output logic                 parity_err,
  input  logic                 clr_status
);

  localparam int NACT = 1 << IR_W;

  logic [SYNC_STAGES-1:0] r_udr_sync;
  logic [SYNC_STAGES-1:0] r_uir_sync;
  logic [SYNC_STAGES-1:0] r_sync_fill;
  logic                   r_udr_hist;
  logic                   r_uir_hist;
  logic                   r_ovf;
  logic [IR_W-1:0]        r_ir_latched;
  logic [NACT-1:0]        r_take_action;
  logic [NACT-1:0]        r_take_no_action;
  logic                   w_udr_rise;
  logic                   w_uir_rise;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_ovf_set;
  logic                   w_par_bad;
  logic                   w_full;
  logic                   w_empty;
  logic [IR_W+SR_W-1:0]   w_head;
  logic [IR_W-1:0]        w_head_ir;

  // History only tracks the chain once it holds real samples, so a strobe held high through reset never looks like a rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_udr_sync  <= '0;
      r_uir_sync  <= '0;
      r_sync_fill <= '0;
      r_udr_hist  <= 1'b1;
      r_uir_hist  <= 1'b1;
    end else begin
      r_udr_sync  <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_sync  <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_sync_fill <= {r_sync_fill[SYNC_STAGES-2:0], 1'b1};
      if (r_sync_fill[SYNC_STAGES-1]) begin
        r_udr_hist <= r_udr_sync[SYNC_STAGES-1];
        r_uir_hist <= r_uir_sync[SYNC_STAGES-1];
      end
    end
  end

  assign w_udr_rise = r_udr_sync[SYNC_STAGES-1] & ~r_udr_hist;
  assign w_uir_rise = r_uir_sync[SYNC_STAGES-1] & ~r_uir_hist;
  assign w_pop      = cmd_valid & cmd_ready;
  assign w_push     = w_udr_rise & ~w_par_bad & (~w_full | w_pop);
  assign w_ovf_set  = w_udr_rise & ~w_par_bad & w_full & ~w_pop;

`ifdef DBG_CMD_PARITY_EN
  logic r_parity_err;

  assign w_par_bad = ^sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      r_parity_err <= 1'b0;
    else if (w_udr_rise & w_par_bad)   r_parity_err <= 1'b1;
    else if (clr_status)               r_parity_err <= 1'b0;
  end

  assign parity_err = r_parity_err;
`else
  assign w_par_bad  = 1'b0;
  assign parity_err = 1'b0;
`endif

  nios_wallet_dbg_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (IR_W + SR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_wdata ({ir_in, sr}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_ir = w_head[IR_W+SR_W-1:SR_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf            <= 1'b0;
      r_ir_latched     <= '0;
      r_take_action    <= '0;
      r_take_no_action <= '0;
    end else begin
      if (w_ovf_set)       r_ovf <= 1'b1;
      else if (clr_status) r_ovf <= 1'b0;
      if (w_uir_rise) r_ir_latched <= ir_in;
      r_take_action    <= '0;
      r_take_no_action <= '0;
      if (w_pop) begin
        if (w_head[ACT_BIT]) r_take_action[w_head_ir]    <= 1'b1;
        else                 r_take_no_action[w_head_ir] <= 1'b1;
      end
    end
  end

  assign cmd_valid      = ~w_empty;
  assign jdo            = w_head[SR_W-1:0];
  assign cmd_ir         = w_head_ir;
  assign ir_latched     = r_ir_latched;
  assign take_action    = r_take_action;
  assign take_no_action = r_take_no_action;
  assign ovf            = r_ovf;

endmodule

// File: tb/tb_nios_wallet_cpu_dbg_cmd_rx.sv
// tb/tb_nios_wallet_cpu_dbg_cmd_rx.sv - randomized bench against a queue-based command receiver model
module tb_nios_wallet_cpu_dbg_cmd_rx;
  import nios_wallet_dbg_pkg::*;

  localparam int SR_W    = 38;
  localparam int IR_W    = 2;
  localparam int S       = 2;
  localparam int DEPTH   = 4;
  localparam int ACT_BIT = 34;
  localparam int NACT    = 4;
`ifdef DBG_CMD_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic            vs_udr;
  logic            vs_uir;
  logic [IR_W-1:0] ir_in;
  logic [SR_W-1:0] sr;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [SR_W-1:0] jdo;
  logic [IR_W-1:0] cmd_ir;
  logic [IR_W-1:0] ir_latched;
  logic [NACT-1:0] take_action;
  logic [NACT-1:0] take_no_action;
  logic            ovf;
  logic            parity_err;
  logic            clr_status;

  int total = 0;
  int bad   = 0;

  logic [IR_W+SR_W-1:0] q[$];
  bit                   udr_s[$];
  bit                   uir_s[$];
  logic                 exp_ovf;
  logic                 exp_perr;
  logic [IR_W-1:0]      exp_irl;
  logic [NACT-1:0]      exp_ta;
  logic [NACT-1:0]      exp_tna;

  nios_wallet_cpu_dbg_cmd_rx #(
    .SR_W(SR_W), .IR_W(IR_W), .SYNC_STAGES(S), .DEPTH(DEPTH), .ACT_BIT(ACT_BIT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .jdo            (jdo),
    .cmd_ir         (cmd_ir),
    .ir_latched     (ir_latched),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .ovf            (ovf),
    .parity_err     (parity_err),
    .clr_status     (clr_status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [SR_W-1:0] mk_sr(input bit odd);
    logic [63:0]     r;
    logic [SR_W-1:0] v;
    r = {$urandom, $urandom};
    v = r[SR_W-1:0];
    v[SR_W-1] = (^v[SR_W-2:0]) ^ odd;
    return v;
  endfunction

  // Strobe samples taken before reset release count as high: nothing is a rise until seen low.
  task automatic model_init();
    q.delete();
    udr_s.delete();
    uir_s.delete();
    repeat (S + 1) begin
      udr_s.push_back(1'b1);
      uir_s.push_back(1'b1);
    end
    exp_ovf  = 1'b0;
    exp_perr = 1'b0;
    exp_irl  = '0;
    exp_ta   = '0;
    exp_tna  = '0;
  endtask

  task automatic tick();
    int                   sz;
    bit                   pop;
    bit                   ru;
    bit                   ri;
    bit                   pbad;
    logic [IR_W+SR_W-1:0] head;
    @(posedge clk);
    udr_s.push_back(vs_udr);
    uir_s.push_back(vs_uir);
    ru = udr_s[1] && !udr_s[0];
    ri = uir_s[1] && !uir_s[0];
    udr_s.delete(0);
    uir_s.delete(0);
    sz   = q.size();
    pop  = (sz != 0) && cmd_ready;
    pbad = PAR_EN && (^sr);
    exp_ta  = '0;
    exp_tna = '0;
    if (pop) begin
      head = q.pop_front();
      if (head[ACT_BIT]) exp_ta[head[SR_W +: IR_W]]  = 1'b1;
      else               exp_tna[head[SR_W +: IR_W]] = 1'b1;
    end
    if (clr_status) begin
      exp_ovf  = 1'b0;
      exp_perr = 1'b0;
    end
    if (ru) begin
      if (pbad)                   exp_perr = 1'b1;
      else if (sz < DEPTH || pop) q.push_back({ir_in, sr});
      else                        exp_ovf = 1'b1;
    end
    if (ri) exp_irl = ir_in;
    @(negedge clk);
    chk("cmd_valid", 64'(cmd_valid), 64'(q.size() != 0));
    chk("ovf", 64'(ovf), 64'(exp_ovf));
    chk("parity_err", 64'(parity_err), 64'(exp_perr));
    chk("ir_latched", 64'(ir_latched), 64'(exp_irl));
    chk("take_action", 64'(take_action), 64'(exp_ta));
    chk("take_no_action", 64'(take_no_action), 64'(exp_tna));
    if (q.size() != 0) begin
      head = q[0];
      chk("jdo", 64'(jdo), 64'(head[SR_W-1:0]));
      chk("cmd_ir", 64'(cmd_ir), 64'(head[SR_W +: IR_W]));
    end
  endtask

  task automatic pulse(input logic [SR_W-1:0] v, input logic [IR_W-1:0] ir);
    sr     = v;
    ir_in  = ir;
    vs_udr = 1'b1;
    tick();
    tick();
    vs_udr = 1'b0;
    repeat (S + 1) tick();
  endtask

  task automatic drain(output int n);
    n = 0;
    cmd_ready = 1'b1;
    repeat (2 * DEPTH + 2) begin
      if (cmd_valid) n++;
      tick();
    end
    cmd_ready = 1'b0;
  endtask

  task automatic rtick();
    cmd_ready  = ($urandom_range(0, 2) == 0);
    clr_status = ($urandom_range(0, 15) == 0);
    if ($urandom_range(0, 3) == 0) vs_uir = ~vs_uir;
    if ($urandom_range(0, 5) == 0) ir_in = IR_W'($urandom);
    tick();
  endtask

  initial begin
    int lat;
    int n;
    reset_n    = 1'b0;
    vs_udr     = 1'b1;
    vs_uir     = 1'b1;
    ir_in      = '0;
    sr         = '0;
    cmd_ready  = 1'b0;
    clr_status = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_ta", 64'(take_action), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    model_init();
    reset_n = 1'b1;

    // 1: strobes high across reset release produce nothing
    repeat (20) tick();
    chk("t1_valid", 64'(cmd_valid), 64'd0);
    chk("t1_irl", 64'(ir_latched), 64'd0);
    vs_udr = 1'b0;
    vs_uir = 1'b0;
    repeat (4) tick();

    // 2: action command on IR_BREAK, first-entry latency
    sr     = 38'h4_0000_0001;
    ir_in  = IR_BREAK;
    vs_udr = 1'b1;
    lat    = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) vs_udr = 1'b0;
      tick();
      lat++;
      if (cmd_valid) break;
    end
    vs_udr = 1'b0;
    chk("t2_latency", 64'(lat), 64'(S + 1));
    chk("t2_jdo", 64'(jdo), 64'h4_0000_0001);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("t2_ta", 64'(take_action), 64'h4);
    tick();
    chk("t2_ta_off", 64'(take_action), 64'h0);

    // 3: no-action command on IR_OCIMEM
    pulse(38'h0_0000_0003, IR_OCIMEM);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("t3_tna", 64'(take_no_action), 64'h1);
    chk("t3_ta", 64'(take_action), 64'h0);
    tick();

    // 4: five commands into a four-entry queue
    for (int k = 0; k < 5; k++) pulse(mk_sr(1'b0), IR_W'(k));
    chk("t4_ovf", 64'(ovf), 64'd1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("t4_ovf_clr", 64'(ovf), 64'd0);

    // 5: push coinciding with pop while full
    sr     = mk_sr(1'b0);
    ir_in  = IR_TRACECTRL;
    vs_udr = 1'b1;
    for (int k = 0; k <= S; k++) begin
      cmd_ready = (k == S);
      if (k == 2) vs_udr = 1'b0;
      tick();
    end
    vs_udr    = 1'b0;
    cmd_ready = 1'b0;
    tick();
    chk("t5_ovf", 64'(ovf), 64'd0);
    drain(n);
    chk("t5_count", 64'(n), 64'd4);

    // 6: odd-parity scan
    pulse(mk_sr(1'b1), IR_TRACEMEM);
    chk("t6_perr", 64'(parity_err), 64'(PAR_EN));
    chk("t6_valid", 64'(cmd_valid), 64'(!PAR_EN));
    drain(n);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("t6_perr_clr", 64'(parity_err), 64'd0);

    // random traffic
    for (int p = 0; p < 80; p++) begin
      sr     = mk_sr($urandom_range(0, 7) == 0);
      ir_in  = IR_W'($urandom);
      vs_udr = 1'b1;
      repeat ($urandom_range(1, 3)) rtick();
      vs_udr = 1'b0;
      repeat ($urandom_range(1, S + 3)) rtick();
    end
    clr_status = 1'b0;
    repeat (S + 2) tick();
    drain(n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
